// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side registered outputs of the ID/EX stage
// Signals:
//   en, flush          pipeline advance and branch/jump kill
//   id_*               decoded instruction presented by ID
//   ex_*               registered instruction seen by EX and the forwarding unit
//   lu_stall           combinational load-use stall request to IF/ID and PC
//   bubble_cnt         saturating count of load-use bubbles since reset
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 32
);
    logic          en, flush, id_valid, id_uses_rt;
    logic [RW-1:0] id_rs, id_rt, id_wsel;
    logic [DW-1:0] id_rdat1, id_rdat2, id_imm, id_npc;
    logic [3:0]    id_aluop;
    logic          id_regwen, id_dren, id_dwen, id_halt;
    logic          ex_valid;
    logic [RW-1:0] ex_rs, ex_rt, ex_wsel;
    logic [DW-1:0] ex_rdat1, ex_rdat2, ex_imm, ex_npc;
    logic [3:0]    ex_aluop;
    logic          ex_regwen, ex_dren, ex_dwen, ex_halt;
    logic          lu_stall;
    logic [CW-1:0] bubble_cnt;
    modport master (
        output en, flush, id_valid, id_uses_rt, id_rs, id_rt, id_wsel,
               id_rdat1, id_rdat2, id_imm, id_npc, id_aluop,
               id_regwen, id_dren, id_dwen, id_halt,
        input  ex_valid, ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_npc,
               ex_aluop, ex_regwen, ex_dren, ex_dwen, ex_halt, lu_stall, bubble_cnt
    );
    modport slave (
        input  en, flush, id_valid, id_uses_rt, id_rs, id_rt, id_wsel,
               id_rdat1, id_rdat2, id_imm, id_npc, id_aluop,
               id_regwen, id_dren, id_dwen, id_halt,
        output ex_valid, ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_npc,
               ex_aluop, ex_regwen, ex_dren, ex_dwen, ex_halt, lu_stall, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard bubble insertion
// Ports:
//   CLK   clock, all state updates on the rising edge
//   nRST  synchronous active-low reset, overrides every other input
//   bus   id_ex_stage_if slave: ID fields in, EX fields / lu_stall / bubble_cnt out
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 32
) (
    input logic          CLK,
    input logic          nRST,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs, rt, wsel;
        logic [DW-1:0] rdat1, rdat2, imm, npc;
        logic [3:0]    aluop;
        logic          regwen, dren, dwen, halt;
    } ex_t;
    ex_t           ex_q, ex_d, cap;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hz;
    // Load in EX whose nonzero destination is read by the real instruction in ID.
    assign hz = ex_q.valid & ex_q.dren & (ex_q.wsel != '0) & bus.id_valid &
                ((ex_q.wsel == bus.id_rs) | (bus.id_uses_rt & (ex_q.wsel == bus.id_rt)));
    assign bus.lu_stall = hz & ~bus.flush;
    always_comb begin
        // Control bits of a non-valid ID slot are squashed; data passes through as presented.
        cap = '{valid: bus.id_valid, rs: bus.id_rs, rt: bus.id_rt, wsel: bus.id_wsel,
                rdat1: bus.id_rdat1, rdat2: bus.id_rdat2, imm: bus.id_imm, npc: bus.id_npc,
                aluop: bus.id_aluop, regwen: bus.id_regwen & bus.id_valid,
                dren: bus.id_dren & bus.id_valid, dwen: bus.id_dwen & bus.id_valid,
                halt: bus.id_halt & bus.id_valid};
        ex_d = ex_q;
        cnt_d = cnt_q;
        if (bus.en) begin
            ex_d = (bus.flush | hz) ? '0 : cap;
            // A flush already kills the slot, so it is not counted as a load-use bubble.
            cnt_d = (bus.lu_stall & ~&cnt_q) ? cnt_q + CW'(1) : cnt_q;
        end
    end
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end
    assign bus.ex_valid   = ex_q.valid;
    assign bus.ex_rs      = ex_q.rs;
    assign bus.ex_rt      = ex_q.rt;
    assign bus.ex_wsel    = ex_q.wsel;
    assign bus.ex_rdat1   = ex_q.rdat1;
    assign bus.ex_rdat2   = ex_q.rdat2;
    assign bus.ex_imm     = ex_q.imm;
    assign bus.ex_npc     = ex_q.npc;
    assign bus.ex_aluop   = ex_q.aluop;
    assign bus.ex_regwen  = ex_q.regwen;
    assign bus.ex_dren    = ex_q.dren;
    assign bus.ex_dwen    = ex_q.dwen;
    assign bus.ex_halt    = ex_q.halt;
    assign bus.bubble_cnt = cnt_q;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Sits between decode and execute. Its registered rs/rt/operand outputs are the EX-side inputs consumed by the forwarding unit.
- Captures decoded instruction fields on each pipeline advance.
- Inserts a bubble and requests an upstream stall when the instruction in EX is a load whose destination is read by the instruction in ID.
- Supports a branch/jump flush and a saturating bubble counter for performance stats.

Parameters:
- DW, 32, data/PC/immediate width
- RW, 5, register index width
- CW, 32, bubble counter width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  synchronous active-low reset, sampled on rising edge of CLK
- en  in  1  pipeline advance (ihit/dhit-derived); 0 = hold all state
- flush  in  1  branch/jump taken; kill instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_wsel  in  RW each  source and destination register indices
- id_uses_rt  in  1  instruction reads rt as a source (R-type, store, branch)
- id_rdat1, id_rdat2, id_imm, id_npc  in  DW each  operands, extended immediate, PC+4
- id_aluop  in  4  ALU operation
- id_regwen, id_dren, id_dwen, id_halt  in  1 each  control bits
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_wsel  out  RW each  registered indices (to forwarding unit)
- ex_rdat1, ex_rdat2, ex_imm, ex_npc  out  DW each  registered data
- ex_aluop  out  4  registered ALU operation
- ex_regwen, ex_dren, ex_dwen, ex_halt  out  1 each  registered control
- lu_stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt  out  CW  load-use bubbles inserted since reset

Behaviour:
- Reset (nRST=0 at edge): every registered output = 0, including ex_valid, all indices/data/control, and bubble_cnt. This takes precedence over en, flush and any hazard, including mid-stall.
- Hazard term: hz = ex_valid & ex_dren & (ex_wsel != 0) & id_valid & ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt))).
- lu_stall = hz & ~flush. It is purely combinational from current EX state and ID inputs, and is asserted regardless of en; upstream acts on it only when en=1.
- Per-edge update priority, highest first:
  1. Reset.
  2. en=0: hold every register, including bubble_cnt.
  3. en=1 & flush=1: load a bubble.
  4. en=1 & hz=1: load a bubble; bubble_cnt += 1, saturating at all-ones.
  5. en=1 otherwise: load every ex_* field from its id_* counterpart; ex_valid = id_valid.
- Bubble contents: ex_valid = 0; ex_regwen, ex_dren, ex_dwen, ex_halt = 0; ex_aluop = 0; ex_rs, ex_rt, ex_wsel = 0 so the forwarding unit never matches. Data fields are don't-care and driven to 0.
- id_valid=0 with en=1 and no flush or hazard: fields are captured as presented, but ex_valid = 0 and ex_regwen, ex_dren, ex_dwen, ex_halt are forced to 0.
- Latency: ID to EX is exactly 1 advancing cycle.
- A load-use hazard costs exactly one bubble. After the bubble, ex_dren = 0, so hz clears and the held ID instruction advances on the next en=1 edge; its operand comes via the WB/MEM forward path.
- The hazard is never raised against register 0.
- Flush and hazard in the same cycle: a single bubble is inserted, bubble_cnt is not incremented, and lu_stall = 0.
- No other internal state.

Test Plan:
- Reset: hold nRST=0 for 2 edges with en=1, id_valid=1, id_regwen=1 -> every ex_* output = 0 and bubble_cnt = 0; outputs stay 0 on the edge nRST returns to 1 only if id inputs are 0.
- Normal capture: en=1, id_rs=3, id_rt=4, id_wsel=5, id_rdat1=0x11, id_imm=0xFFFF_FFF0, id_regwen=1 -> after 1 edge, ex_rs=3, ex_rt=4, ex_wsel=5, ex_rdat1=0x11, ex_imm=0xFFFF_FFF0, ex_valid=1; with en=0 for 3 edges, values unchanged.
- Load-use on rs: EX holds lw with ex_wsel=8; ID presents id_rs=8 -> lu_stall=1; next edge ex_valid=0, ex_wsel=0, bubble_cnt=1. The following edge captures the ID instruction with lu_stall=0.
- Load-use on rt gated by id_uses_rt: EX lw ex_wsel=9; ID id_rt=9 with id_uses_rt=0 -> lu_stall=0 and no bubble; with id_uses_rt=1 -> lu_stall=1. Load to $0 with id_rs=0 -> lu_stall=0.
- Flush plus hazard: hazard condition present with flush=1, en=1 -> lu_stall=0, bubble inserted, bubble_cnt unchanged. Repeat with en=0 -> all state held.
- Counter saturation (CW=4 build): force 16 hazard bubbles -> bubble_cnt stops at 0xF.
